// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding and
// instruction-word constants.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t FETCH_REQ  = 2'd0;
  localparam fetch_state_t FETCH_WAIT = 2'd1;
  localparam fetch_state_t FETCH_HOLD = 2'd2;
  localparam fetch_state_t FETCH_DONE = 2'd3;

  // An all-zero word marks end of program and is never delivered downstream.
  localparam logic [31:0] ZERO_INST  = 32'h0000_0000;
  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch bus: instruction memory request/response, redirect strobe and the
// decode-side valid/ready handshake.
interface fetch_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_ready;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc;
  logic            fetch_complete;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, pc, fetch_complete,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, pc, fetch_complete,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, keeps at most one memory request in
// flight, hands instructions to decode and flags end of program.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_WORDS = 256
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  // One extra bit so a pc near the top of the address space cannot wrap past the bound.
  localparam logic [XLEN:0] FETCH_BOUND = (XLEN+1)'(IMEM_WORDS * INST_BYTES);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;
  logic            drop_q, drop_d;
  logic            done_q, done_d;
  logic            at_bound;
  logic            outstanding;

  assign at_bound    = {1'b0, pc_q} >= FETCH_BOUND;
  assign outstanding = (state_q == FETCH_WAIT) || drop_q;

  // While a stale response is still owed, hold off the next request so only one is ever in flight.
  assign bus.imem_req = (state_q == FETCH_REQ) && !at_bound && !drop_q &&
                        !bus.redirect_valid && !reset;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.pc             = pc_q;
  assign bus.fetch_complete = done_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;

    if (state_q != FETCH_DONE && bus.redirect_valid) begin
      pc_d         = bus.redirect_pc & ~XLEN'(3);
      inst_valid_d = 1'b0;
      state_d      = FETCH_REQ;
      drop_d       = outstanding && !bus.imem_rvalid;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (drop_q) begin
            if (bus.imem_rvalid) drop_d = 1'b0;
          end else if (at_bound) begin
            state_d = FETCH_DONE;
          end else begin
            state_d = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = FETCH_REQ;
            end else if (bus.imem_rdata == XLEN'(ZERO_INST)) begin
              state_d = FETCH_DONE;
            end else begin
              inst_d       = bus.imem_rdata;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + XLEN'(INST_BYTES);
              state_d      = FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (bus.dec_ready) begin
            inst_valid_d = 1'b0;
            state_d      = FETCH_REQ;
          end
        end
        default: ;
      endcase
    end

    done_d = done_q || (state_d == FETCH_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      drop_q       <= drop_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a full-size instance driven through a
// sequence of scenarios, plus a two-word instance that runs to its fetch bound.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic reset;
  logic reset_b;

  always #5 clk = ~clk;

  fetch_if #(.XLEN(32)) a_if ();
  fetch_if #(.XLEN(32)) b_if ();

  fetch_controller #(.XLEN(32), .RESET_PC(32'h0), .IMEM_WORDS(256)) u_dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if)
  );

  fetch_controller #(.XLEN(32), .RESET_PC(32'h0), .IMEM_WORDS(2)) u_dut_b (
    .clk  (clk),
    .reset(reset_b),
    .bus  (b_if)
  );

  // Memory models: fixed latency, one response per request, not cleared by reset.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int          lat_a = 1;
  logic        a_pend = 1'b0;
  int          a_cnt = 0;
  logic [31:0] a_paddr = '0;
  logic        b_pend = 1'b0;
  int          b_cnt = 0;
  logic [31:0] b_paddr = '0;

  always @(posedge clk) begin
    if (a_if.imem_req) begin
      a_pend  <= 1'b1;
      a_cnt   <= lat_a - 1;
      a_paddr <= a_if.imem_addr;
    end else if (a_pend) begin
      if (a_cnt == 0) a_pend <= 1'b0;
      else            a_cnt  <= a_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (b_if.imem_req) begin
      b_pend  <= 1'b1;
      b_cnt   <= 0;
      b_paddr <= b_if.imem_addr;
    end else if (b_pend) begin
      b_pend <= 1'b0;
    end
  end

  assign a_if.imem_rvalid = a_pend && (a_cnt == 0);
  assign a_if.imem_rdata  = a_if.imem_rvalid ? mem_a[a_paddr[9:2]] : 32'hDEAD_BEEF;
  assign b_if.imem_rvalid = b_pend;
  assign b_if.imem_rdata  = b_if.imem_rvalid ? mem_b[b_paddr[9:2]] : 32'hDEAD_BEEF;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb_a [$];
  logic [63:0] sb_b [$];
  logic [31:0] req_a [$];
  logic [31:0] req_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic chk_inst(input string tag, ref logic [63:0] sb [$],
                          input logic [31:0] inst, input logic [31:0] ipc);
    logic [63:0] e;
    n_checks++;
    assert (sb.size() != 0) n_pass++;
    else $error("FAIL %s_spurious: observed inst %h pc %h required no instruction", tag, inst, ipc);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_inst"}, inst, e[63:32]);
      chk({tag, "_pc"}, ipc, e[31:0]);
      $display("%s handshake inst=%h pc=%h", tag, inst, ipc);
    end
  endtask

  // Inputs for the coming posedge are already set; sample, then wait for the next negedge.
  task automatic tick();
    #1;
    if (a_if.imem_req) req_a.push_back(a_if.imem_addr);
    if (b_if.imem_req) req_b.push_back(b_if.imem_addr);
    if (a_if.inst_valid && a_if.dec_ready) chk_inst("a", sb_a, a_if.inst, a_if.inst_pc);
    if (b_if.inst_valid && b_if.dec_ready) chk_inst("b", sb_b, b_if.inst, b_if.inst_pc);
    @(negedge clk);
  endtask

  task automatic chk_reqs(input string tag, input int n,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({tag, "_req_count"}, 32'(req_a.size()), 32'(n));
    for (int i = 0; i < n && i < req_a.size(); i++) chk({tag, "_req_addr"}, req_a[i], e[i]);
  endtask

  task automatic reset_a();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    req_a.delete();
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound && !a_if.fetch_complete; i++) tick();
    chk({tag, "_complete"}, 32'(a_if.fetch_complete), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb_a.size()), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    reset_b = 1'b1;
    a_if.redirect_valid = 1'b0;
    a_if.redirect_pc    = '0;
    a_if.dec_ready      = 1'b1;
    b_if.redirect_valid = 1'b0;
    b_if.redirect_pc    = '0;
    b_if.dec_ready      = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h1000_0000 + 32'(i);
      mem_b[i] = 32'h2000_0000 + 32'(i);
    end
    sb_b.push_back({32'h2000_0000, 32'h0});
    sb_b.push_back({32'h2000_0001, 32'h4});

    // Reset state
    mem_a[0] = 32'h0050_0093;
    mem_a[1] = 32'h00A0_0113;
    mem_a[2] = 32'h0000_0000;
    lat_a = 1;
    tick();
    tick();
    chk("rst_inst_valid", 32'(a_if.inst_valid), 32'd0);
    chk("rst_inst", a_if.inst, 32'h0);
    chk("rst_inst_pc", a_if.inst_pc, 32'h0);
    chk("rst_pc", a_if.pc, 32'h0);
    chk("rst_complete", 32'(a_if.fetch_complete), 32'd0);
    chk("rst_imem_req", 32'(a_if.imem_req), 32'd0);

    // Straight-line program ending in a zero word
    sb_a.push_back({32'h0050_0093, 32'h0});
    sb_a.push_back({32'h00A0_0113, 32'h4});
    reset   = 1'b0;
    reset_b = 1'b0;
    wait_done("line", 40);
    for (int i = 0; i < 5; i++) tick();
    chk_reqs("line", 3, 32'h0, 32'h4, 32'h8);
    chk("line_sticky", 32'(a_if.fetch_complete), 32'd1);

    // Backpressure holds the first instruction stable
    mem_a[0] = 32'h0000_0011;
    mem_a[1] = 32'h0000_0022;
    mem_a[2] = 32'h0;
    a_if.dec_ready = 1'b0;
    sb_a.push_back({32'h0000_0011, 32'h0});
    reset_a();
    for (int i = 0; i < 20 && !a_if.inst_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(a_if.inst_valid), 32'd1);
      chk("bp_inst", a_if.inst, 32'h0000_0011);
      chk("bp_inst_pc", a_if.inst_pc, 32'h0);
      chk("bp_no_req", 32'(a_if.imem_req), 32'd0);
    end
    a_if.dec_ready = 1'b1;
    sb_a.push_back({32'h0000_0022, 32'h4});
    wait_done("bp", 40);
    chk_reqs("bp", 3, 32'h0, 32'h4, 32'h8);

    // Redirect while waiting on a slow response
    mem_a[0]  = 32'h0000_0033;
    mem_a[16] = 32'h0000_0044;
    mem_a[17] = 32'h0;
    lat_a = 3;
    sb_a.push_back({32'h0000_0044, 32'h40});
    reset_a();
    tick();
    a_if.redirect_valid = 1'b1;
    a_if.redirect_pc    = 32'h42;
    tick();
    a_if.redirect_valid = 1'b0;
    chk("rw_pc_aligned", a_if.pc, 32'h40);
    wait_done("rw", 60);
    chk_reqs("rw", 3, 32'h0, 32'h40, 32'h44);

    // Redirect in the same cycle as the response
    mem_a[0] = 32'h0000_0055;
    mem_a[8] = 32'h0000_0066;
    mem_a[9] = 32'h0;
    lat_a = 2;
    sb_a.push_back({32'h0000_0066, 32'h20});
    reset_a();
    for (int i = 0; i < 10 && !a_if.imem_rvalid; i++) tick();
    chk("rc_rvalid_seen", 32'(a_if.imem_rvalid), 32'd1);
    a_if.redirect_valid = 1'b1;
    a_if.redirect_pc    = 32'h20;
    tick();
    a_if.redirect_valid = 1'b0;
    wait_done("rc", 40);
    chk_reqs("rc", 3, 32'h0, 32'h20, 32'h24);

    // Reset while a response is outstanding
    mem_a[0] = 32'h0000_0077;
    mem_a[1] = 32'h0;
    reset_a();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_stale_rvalid", 32'(a_if.imem_rvalid), 32'd1);
    chk("mr_inst_valid", 32'(a_if.inst_valid), 32'd0);
    chk("mr_inst", a_if.inst, 32'h0);
    chk("mr_inst_pc", a_if.inst_pc, 32'h0);
    chk("mr_req", 32'(a_if.imem_req), 32'd1);
    chk("mr_addr", a_if.imem_addr, 32'h0);
    req_a.delete();
    sb_a.push_back({32'h0000_0077, 32'h0});
    wait_done("mr", 40);
    chk_reqs("mr", 2, 32'h0, 32'h4, 32'h0);

    // Two-word instance stops at its bound
    chk("bnd_complete", 32'(b_if.fetch_complete), 32'd1);
    chk("bnd_sb_empty", 32'(sb_b.size()), 32'd0);
    chk("bnd_req_count", 32'(req_b.size()), 32'd2);
    if (req_b.size() >= 2) begin
      chk("bnd_req0", req_b[0], 32'h0);
      chk("bnd_req1", req_b[1], 32'h4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
